// File: rtl/pkt_rx_pkg.sv
// rtl/pkt_rx_pkg.sv - control codes and framer state type shared by the packet receive path
package pkt_rx_pkg;
   localparam logic [7:0] CTL_INVALID = 8'h00;
   localparam logic [7:0] CTL_START   = 8'h01;
   localparam logic [7:0] CTL_STOP    = 8'h02;
   localparam logic [7:0] CTL_SINGLE  = 8'h03;
   localparam logic [7:0] CTL_DATA    = 8'h04;

   typedef enum logic [1:0] {IDLE, IN_PKT, DROP} rx_state_t;
endpackage

// File: rtl/pkt_rx_cfifo.sv
// rtl/pkt_rx_cfifo.sv - commit/rollback beat FIFO: speculative writes become visible only on commit
module pkt_rx_cfifo #(
   parameter int DATA_W = 512,
   parameter int DEPTH  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    push_sop,
   input  logic                    push_eop,
   input  logic [DATA_W-1:0]       push_data,
   input  logic                    commit,
   input  logic                    rewind,
   input  logic                    pop,
   output logic [$clog2(DEPTH):0]  free,
   output logic [$clog2(DEPTH):0]  free_cm,
   output logic                    out_valid,
   output logic                    out_sop,
   output logic                    out_eop,
   output logic [DATA_W-1:0]       out_data
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE     = (AW+1)'(1);

   logic [DATA_W+1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr, commit_ptr, rd_ptr, base, next_wr;

   // A rewind takes effect before the write of the same cycle, so the new beat lands at commit_ptr.
   assign base    = rewind ? commit_ptr : wr_ptr;
   assign next_wr = push ? base + ONE : base;

   assign free      = DEPTH_V - (wr_ptr - rd_ptr);
   assign free_cm   = DEPTH_V - (commit_ptr - rd_ptr);
   assign out_valid = (rd_ptr != commit_ptr);
   assign {out_sop, out_eop, out_data} = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
      end else begin
         wr_ptr <= next_wr;
         if (commit)
            commit_ptr <= next_wr;
         if (pop && out_valid)
            rd_ptr <= rd_ptr + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[base[AW-1:0]] <= {push_sop, push_eop, push_data};
   end
endmodule

// File: rtl/pkt_rx_framer.sv
// rtl/pkt_rx_framer.sv - packet bus framing check with store-and-forward release of whole packets
// Optional statistics counters rx_pkt_cnt/rx_err_cnt are built when PKT_RX_STATS_EN is defined.
module pkt_rx_framer
   import pkt_rx_pkg::*;
#(
   parameter int DATA_W = 512,
   parameter int CTL_W  = 8,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] pkt_data_in,
   input  logic [CTL_W-1:0]  pkt_ctl_in,
   output logic              rdy,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sop,
   output logic              out_eop,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              err_pulse
`ifdef PKT_RX_STATS_EN
   ,
   output logic [CNT_W-1:0]  rx_pkt_cnt,
   output logic [CNT_W-1:0]  rx_err_cnt
`endif
);
   rx_state_t               state, state_d;
   logic                    push, sop, eop, commit, rewind, err_d;
   logic [$clog2(DEPTH):0]  free, free_cm;
   logic                    is_invalid, is_start, is_stop, is_single, is_data, is_bad;

   assign is_invalid = (pkt_ctl_in == CTL_W'(CTL_INVALID));
   assign is_start   = (pkt_ctl_in == CTL_W'(CTL_START));
   assign is_stop    = (pkt_ctl_in == CTL_W'(CTL_STOP));
   assign is_single  = (pkt_ctl_in == CTL_W'(CTL_SINGLE));
   assign is_data    = (pkt_ctl_in == CTL_W'(CTL_DATA));
   assign is_bad     = (pkt_ctl_in >  CTL_W'(CTL_DATA));

   always_comb begin
      push    = 1'b0;
      sop     = 1'b0;
      eop     = 1'b0;
      commit  = 1'b0;
      rewind  = 1'b0;
      err_d   = 1'b0;
      state_d = state;
      // Start codes open a packet from any state; free_cm is the space left once any partial packet is rewound.
      if (is_start || is_single) begin
         rewind = (state == IN_PKT);
         err_d  = (state == IN_PKT);
         if (free_cm == '0) begin
            rewind  = 1'b1;
            err_d   = 1'b1;
            state_d = is_single ? IDLE : DROP;
         end else begin
            push    = 1'b1;
            sop     = 1'b1;
            eop     = is_single;
            commit  = is_single;
            state_d = is_single ? IDLE : IN_PKT;
         end
      end else begin
         case (state)
            IN_PKT: begin
               if (is_data || is_stop) begin
                  if (free == '0) begin
                     rewind  = 1'b1;
                     err_d   = 1'b1;
                     state_d = DROP;
                  end else begin
                     push   = 1'b1;
                     eop    = is_stop;
                     commit = is_stop;
                     if (is_stop)
                        state_d = IDLE;
                  end
               end else if (is_bad) begin
                  rewind  = 1'b1;
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
            DROP: begin
               if (is_stop)
                  state_d = IDLE;
            end
            default: begin
               if (!is_invalid)
                  err_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         err_pulse <= 1'b0;
      end else begin
         state     <= state_d;
         err_pulse <= err_d;
      end
   end

   assign rdy = (free != '0) && (state != DROP);

`ifdef PKT_RX_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_pkt_cnt <= '0;
         rx_err_cnt <= '0;
      end else begin
         if (commit && rx_pkt_cnt != '1)
            rx_pkt_cnt <= rx_pkt_cnt + CNT_W'(1);
         if (err_d && rx_err_cnt != '1)
            rx_err_cnt <= rx_err_cnt + CNT_W'(1);
      end
   end
`endif

   pkt_rx_cfifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_cfifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_sop  (sop),
      .push_eop  (eop),
      .push_data (pkt_data_in),
      .commit    (commit),
      .rewind    (rewind),
      .pop       (out_ready),
      .free      (free),
      .free_cm   (free_cm),
      .out_valid (out_valid),
      .out_sop   (out_sop),
      .out_eop   (out_eop),
      .out_data  (out_data)
   );
endmodule

// File: tb/tb_pkt_rx_framer.sv
// tb/tb_pkt_rx_framer.sv - table-driven bench with output scoreboard for pkt_rx_framer (DEPTH=4)
module tb_pkt_rx_framer;
   localparam int DATA_W = 512;
   localparam int CTL_W  = 8;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] pkt_data_in;
   logic [CTL_W-1:0]  pkt_ctl_in;
   logic              rdy, out_sop, out_eop, out_valid, out_ready, err_pulse;
   logic [DATA_W-1:0] out_data;
`ifdef PKT_RX_STATS_EN
   logic [CNT_W-1:0]  rx_pkt_cnt, rx_err_cnt;
`endif

   always #5 clk = ~clk;

   pkt_rx_framer #(.DATA_W(DATA_W), .CTL_W(CTL_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .pkt_data_in (pkt_data_in),
      .pkt_ctl_in  (pkt_ctl_in),
      .rdy         (rdy),
      .out_data    (out_data),
      .out_sop     (out_sop),
      .out_eop     (out_eop),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .err_pulse   (err_pulse)
`ifdef PKT_RX_STATS_EN
      ,
      .rx_pkt_cnt  (rx_pkt_cnt),
      .rx_err_cnt  (rx_err_cnt)
`endif
   );

   typedef struct packed {
      logic              sop;
      logic              eop;
      logic [DATA_W-1:0] data;
   } beat_t;

   typedef struct {
      logic [15:0] data;
      logic [7:0]  ctl;
      bit          rdy_in;
      bit          e_err;
      bit          e_out;
      bit          e_sop;
      bit          e_eop;
      bit          chk_rdy;
      bit          e_rdy;
   } vec_t;

   beat_t exp_q[$];
   vec_t  tbl[$];
   int    n_vec = 0;
   int    n_bad = 0;

   task automatic check(input string name, input logic [DATA_W+1:0] act, input logic [DATA_W+1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [15:0] d, input logic [7:0] c, input bit r, input bit e,
                      input bit o, input bit s, input bit eo, input bit cr, input bit er);
      vec_t v;
      v.data = d; v.ctl = c; v.rdy_in = r; v.e_err = e; v.e_out = o;
      v.e_sop = s; v.e_eop = eo; v.chk_rdy = cr; v.e_rdy = er;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic [15:0] d, input logic [7:0] c);
      pkt_data_in = DATA_W'(d);
      pkt_ctl_in  = c;
      @(posedge clk); #1;
   endtask

   task automatic drain(input string name);
      pkt_ctl_in = '0;
      out_ready  = 1'b1;
      for (int k = 0; k < 20 && exp_q.size() != 0; k++)
         @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      check({name, "_pending"}, exp_q.size(), 0);
      check({name, "_valid_after"}, out_valid, 0);
   endtask

   // Scoreboard: every accepted output beat must match the next expected beat in order.
   always @(negedge clk) begin
      beat_t e;
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_beat: got %0h sop=%0b eop=%0b, want none", out_data, out_sop, out_eop);
         end else begin
            e = exp_q.pop_front();
            check("out_beat", {out_sop, out_eop, out_data}, e);
         end
      end
   end

   initial begin
      int exp_pkts, exp_errs;
      reset       = 1'b1;
      pkt_data_in = '0;
      pkt_ctl_in  = '0;
      out_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_out_valid", out_valid, 0);
      check("reset_err_pulse", err_pulse, 0);
      check("reset_rdy", rdy, 1);
`ifdef PKT_RX_STATS_EN
      check("reset_pkt_cnt", rx_pkt_cnt, 0);
      check("reset_err_cnt", rx_err_cnt, 0);
`endif

      //   data    ctl    rdy err out sop eop chk rdy
      add(16'ha, 8'h01, 1, 0, 1, 1, 0, 0, 0);
      add(16'h0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
      add(16'hb, 8'h02, 1, 0, 1, 0, 1, 0, 0);
      add(16'hc, 8'h03, 1, 0, 1, 1, 1, 0, 0);
      add(16'hd, 8'h00, 1, 0, 0, 0, 0, 0, 0);
      add(16'hb, 8'h02, 1, 1, 0, 0, 0, 0, 0);
      add(16'h7, 8'h07, 1, 1, 0, 0, 0, 0, 0);
      add(16'ha, 8'h01, 1, 0, 0, 0, 0, 0, 0);
      add(16'h5, 8'h01, 1, 1, 1, 1, 0, 0, 0);
      add(16'h6, 8'h02, 1, 0, 1, 0, 1, 0, 0);
      add(16'h1, 8'h01, 1, 0, 0, 0, 0, 0, 0);
      add(16'h2, 8'h09, 1, 1, 0, 0, 0, 0, 0);
      add(16'h0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
      add(16'h0, 8'h00, 1, 0, 0, 0, 0, 1, 1);
      add(16'h1, 8'h01, 0, 0, 0, 0, 0, 0, 0);
      add(16'h2, 8'h04, 0, 0, 0, 0, 0, 0, 0);
      add(16'h3, 8'h04, 0, 0, 0, 0, 0, 0, 0);
      add(16'h4, 8'h04, 0, 0, 0, 0, 0, 1, 0);
      add(16'h5, 8'h04, 0, 1, 0, 0, 0, 1, 0);
      add(16'h6, 8'h04, 0, 0, 0, 0, 0, 1, 0);
      add(16'h7, 8'h02, 0, 0, 0, 0, 0, 1, 1);
      add(16'hc, 8'h03, 0, 0, 1, 1, 1, 0, 0);

      exp_pkts = 0;
      exp_errs = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         pkt_data_in = DATA_W'(tbl[i].data);
         pkt_ctl_in  = tbl[i].ctl;
         out_ready   = tbl[i].rdy_in;
         if (tbl[i].e_out)
            exp_q.push_back({tbl[i].e_sop, tbl[i].e_eop, DATA_W'(tbl[i].data)});
         if (tbl[i].e_out && tbl[i].e_eop)
            exp_pkts++;
         if (tbl[i].e_err)
            exp_errs++;
         @(posedge clk); #1;
         check($sformatf("err_pulse[%0d]", i), err_pulse, tbl[i].e_err);
         if (tbl[i].chk_rdy)
            check($sformatf("rdy[%0d]", i), rdy, tbl[i].e_rdy);
      end
      drain("table");
`ifdef PKT_RX_STATS_EN
      check("table_pkt_cnt", rx_pkt_cnt, exp_pkts);
      check("table_err_cnt", rx_err_cnt, exp_errs);
`endif

      // Reset mid-packet throws away a committed packet and a partial one.
      out_ready = 1'b0;
      drive(16'he1, 8'h03);
      drive(16'hf1, 8'h01);
      drive(16'hf2, 8'h04);
      check("pre_reset_valid", out_valid, 1);
      reset      = 1'b1;
      pkt_ctl_in = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midpkt_reset_valid", out_valid, 0);
      check("midpkt_reset_rdy", rdy, 1);
      check("midpkt_reset_err", err_pulse, 0);
`ifdef PKT_RX_STATS_EN
      check("midpkt_reset_pkt_cnt", rx_pkt_cnt, 0);
`endif

      // Single-beat packet is visible right after its sampling edge.
      exp_q.push_back({1'b1, 1'b1, DATA_W'(16'hee)});
      drive(16'hee, 8'h03);
      check("single_latency_valid", out_valid, 1);
      check("single_latency_data", {out_sop, out_eop, out_data}, {1'b1, 1'b1, DATA_W'(16'hee)});
      check("single_latency_err", err_pulse, 0);
      drain("after_reset");
`ifdef PKT_RX_STATS_EN
      check("after_reset_pkt_cnt", rx_pkt_cnt, 1);
      check("after_reset_err_cnt", rx_err_cnt, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
